// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader for the instruction memory of the single-cycle MIPS core.
//   A byte stream (valid/ready) carries a frame:
//   LEN_HI, LEN_LO, N*4 big-endian payload bytes, and an XOR checksum byte.
//   Each assembled word is written to consecutive word addresses. The core is
//   held in reset until the whole image has been written and its checksum
//   has been verified.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        one-cycle arm request (honoured in IDLE, DONE, ERROR)
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle (registered)
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    byte address of the word being written (word_index*4)
//   imem_wdata   instruction word being written
//   cpu_reset    reset request to the core, released only in DONE
//   done         image loaded and verified
//   error        load aborted
//   err_code     01 = bad length, 10 = checksum mismatch, 00 = none
//   words_loaded number of words written in the current load
module imem_loader #(
    parameter int WORDS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic [7:0]       r_len_hi;
    logic [CNT_W-1:0] r_n;
    logic [7:0]       r_acc;
    logic [23:0]      r_shift;
    logic [1:0]       r_bidx;
    logic [CNT_W-1:0] r_words;
    logic             r_in_ready;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_cpu_reset;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;

    logic             w_accept;
    logic [15:0]      w_len;
    logic             w_len_bad;
    logic [31:0]      w_word;
    logic [CNT_W-1:0] w_words_inc;
    state_t           w_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_len       = {r_len_hi, in_data};
    assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'(WORDS));
    assign w_word      = {r_shift, in_data};
    assign w_words_inc = r_words + CNT_W'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA;
            S_DATA:   if (w_accept && r_bidx == 2'd3) w_next = S_WRITE;
            S_WRITE:  w_next = (w_words_inc < r_n) ? S_DATA : S_CHECK;
            S_CHECK:  if (w_accept) w_next = (in_data == r_acc) ? S_DONE : S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len_hi    <= '0;
            r_n         <= '0;
            r_acc       <= '0;
            r_shift     <= '0;
            r_bidx      <= '0;
            r_words     <= '0;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK});
            r_cpu_reset <= (w_next != S_DONE);
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERROR);
            r_we        <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_words    <= '0;
                        r_acc      <= '0;
                        r_bidx     <= '0;
                        r_err_code <= 2'b00;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= in_data;
                        r_acc    <= r_acc ^ in_data;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_acc  <= r_acc ^ in_data;
                        r_n    <= CNT_W'(w_len);
                        r_bidx <= '0;
                        if (w_len_bad) r_err_code <= 2'b01;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_acc   <= r_acc ^ in_data;
                        r_shift <= {r_shift[15:0], in_data};
                        r_bidx  <= r_bidx + 2'd1;
                        // The write strobe and its address/data are launched
                        // here so they are stable for the whole WRITE cycle.
                        if (r_bidx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= 32'({r_words, 2'b00});
                            r_wdata <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                end
                S_CHECK: begin
                    if (w_accept && in_data != r_acc) r_err_code <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. Frames are built and their expected
//   outcome (writes, status, error cause) is derived from the frame rules:
//   big-endian length, big-endian words at word_index*4, XOR checksum.
module tb_imem_loader;

    localparam int WORDS = 32;
    localparam int CNT_W = 6;

    typedef logic [7:0]  bq_t[$];
    typedef logic [63:0] wq_t[$];
    typedef logic [31:0] dq_t[$];

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_reset;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_timeout = 0;
    int unsigned cyc = 0;
    wq_t         wr_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t make_frame(input logic [15:0] n, input dq_t ws);
        bq_t        f;
        logic [7:0] x;
        f = {};
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
        foreach (ws[k]) begin
            f.push_back(ws[k][31:24]);
            f.push_back(ws[k][23:16]);
            f.push_back(ws[k][15:8]);
            f.push_back(ws[k][7:0]);
        end
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        f.push_back(x);
        return f;
    endfunction

    function automatic dq_t rand_words(input int unsigned n);
        dq_t ws;
        ws = {};
        for (int unsigned i = 0; i < n; i++) ws.push_back($urandom);
        return ws;
    endfunction

    // Reference outcome of a frame.
    function automatic void model(input bq_t fr, output wq_t w, output bit ok,
                                  output logic [1:0] code, output int unsigned wl);
        int unsigned n;
        logic [7:0]  x;
        w = {};
        n = {fr[0], fr[1]};
        if (n == 0 || n > WORDS) begin
            ok = 1'b0; code = 2'b01; wl = 0;
            return;
        end
        x = 8'h00;
        for (int unsigned i = 0; i + 1 < fr.size(); i++) x ^= fr[i];
        for (int unsigned k = 0; k < n; k++)
            w.push_back({32'(k * 4), fr[2+4*k], fr[3+4*k], fr[4+4*k], fr[5+4*k]});
        ok   = (fr[fr.size()-1] == x);
        code = ok ? 2'b00 : 2'b10;
        wl   = n;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
        int unsigned gap;
        bit          rdy;
        bit          got;
        gap = (maxgap != 0) ? $urandom_range(0, maxgap) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);   // ignored mid-load
            tick();
            start    = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            got = rdy;
        end
        if (!got) n_timeout++;
    endtask

    task automatic load(input string tag, input bq_t fr, input int unsigned maxgap);
        int unsigned t0;
        int          lat;
        wq_t         ew;
        bit          ok;
        logic [1:0]  code;
        int unsigned wl;

        wr_q.delete();
        n_timeout = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        foreach (fr[i]) send_byte(fr[i], maxgap);
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done || error) begin
                lat = int'(cyc - t0);
                break;
            end
        end

        model(fr, ew, ok, code, wl);
        chk({tag, ".accept_timeouts"}, 64'(n_timeout), 64'd0);
        chk({tag, ".finished"}, 64'(lat >= 0), 64'd1);
        chk({tag, ".nwrites"}, 64'(wr_q.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size(); i++)
            if (i < wr_q.size()) chk($sformatf("%s.write%0d", tag, i), wr_q[i], ew[i]);
        chk({tag, ".done"}, 64'(done), 64'(ok));
        chk({tag, ".error"}, 64'(error), 64'(!ok));
        chk({tag, ".err_code"}, 64'(err_code), 64'(code));
        chk({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(!ok));
        chk({tag, ".words_loaded"}, 64'(words_loaded), 64'(wl));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        if (ew.size() > 0) chk({tag, ".addr_hold"}, 64'(imem_addr), 64'(ew[ew.size()-1][63:32]));
        if (ok && maxgap == 0) chk({tag, ".latency"}, 64'(lat), 64'(2 + 5 * wl + 1));
    endtask

    initial begin
        bq_t fr;
        dq_t ws;

        // Reset with a live stream and a simultaneous start.
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        tick();
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.imem_we", 64'(imem_we), 64'd0);
        chk("rst.imem_addr", 64'(imem_addr), 64'd0);
        chk("rst.imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst.cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.error", 64'(error), 64'd0);
        chk("rst.err_code", 64'(err_code), 64'd0);
        chk("rst.words_loaded", 64'(words_loaded), 64'd0);
        chk("rst.nwrites", 64'(wr_q.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle.in_ready", 64'(in_ready), 64'd0);

        // Reference image from the test plan.
        fr = {8'h00, 8'h02, 8'h01, 8'h4B, 8'h48, 8'h20, 8'h01, 8'h94, 8'h50, 8'h22, 8'hC7};
        load("good", fr, 0);
        chk("good.w0", wr_q.size() > 0 ? wr_q[0] : 64'hX, {32'd0, 32'h014B4820});
        chk("good.w1", wr_q.size() > 1 ? wr_q[1] : 64'hX, {32'd4, 32'h01945022});

        load("len21", {8'h00, 8'h21}, 0);
        load("len00", {8'h00, 8'h00}, 0);
        load("len0101", {8'h01, 8'h01}, 0);

        fr = {8'h00, 8'h02, 8'h01, 8'h4B, 8'h48, 8'h20, 8'h01, 8'h94, 8'h50, 8'h22, 8'h00};
        load("badchk", fr, 0);

        // Random images, stalled source.
        for (int t = 0; t < 4; t++) begin
            ws = rand_words($urandom_range(1, 6));
            load($sformatf("rnd%0d", t), make_frame(16'(ws.size()), ws), 3);
        end
        ws = rand_words(3);
        fr = make_frame(16'd3, ws);
        fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
        load("rndbadchk", fr, 2);

        // Reset in the middle of a word, then a fresh one-word load.
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        in_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clk);
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        chk("midrst.cpu_reset", 64'(cpu_reset), 64'd1);
        chk("midrst.words_loaded", 64'(words_loaded), 64'd0);
        ws = rand_words(1);
        load("after_midrst", make_frame(16'd1, ws), 0);

        // Re-arm from DONE, then a full-capacity image.
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        chk("rearm.cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rearm.done", 64'(done), 64'd0);
        chk("rearm.in_ready", 64'(in_ready), 64'd1);
        chk("rearm.words_loaded", 64'(words_loaded), 64'd0);
        ws = rand_words(WORDS);
        load("full", make_frame(16'(WORDS), ws), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
